timing_phase_sequencer: RTL
===========================

// Module: timing_phase_sequencer
// PURPOSE
//  Sequences the timing module: steps a phase index through 0..last_phase for a
//  programmed number of cycles, holding each phase a programmable dwell time.
//  It emits phase and cycle strobes that downstream phase counters and strobe
//  logic consume, and has a start/busy/done handshake towards the host control logic.
// PARAMETERS
//  PHASE_W  4  width of phase index and last_phase (max 2^PHASE_W phases/cycle)
//  CYC_W    8  width of num_cycles and cycles_left
//  DWELL_W  4  width of dwell; each phase lasts dwell+1 clocks
// PORTS
//  clk           in   1        system clock, all logic on rising edge
//  reset_n       in   1        asynchronous, active-low reset
//  start         in   1        run request; sampled only in IDLE
//  abort         in   1        cancel run; honoured only in RUN
//  num_cycles    in   CYC_W    cycles to run; sampled on accepted start
//  last_phase    in   PHASE_W  final phase index of a cycle; sampled on start
//  dwell         in   DWELL_W  clocks per phase minus 1; sampled on start
//  busy          out  1        high while in RUN
//  done          out  1        one-clock pulse after normal completion
//  phase         out  PHASE_W  current phase index
//  phase_strobe  out  1        high on first clock of every phase
//  cycle_strobe  out  1        high on first clock of every cycle (phase 0)
//  cycles_left   out  CYC_W    cycles remaining, including current one
// BEHAVIOUR
//  - All outputs registered. reset_n low: state=IDLE; busy, done, phase,
//    strobes, cycles_left all 0 immediately; internal dwell counter 0.
//  - States: IDLE, RUN, DONE.
//  - IDLE, start=1, num_cycles!=0: next edge -> RUN, busy=1, phase=0,
//    phase_strobe=1, cycle_strobe=1, cycles_left=num_cycles (latency 1 clock).
//  - IDLE, start=1, num_cycles==0: next edge -> DONE; busy stays 0, no strobes.
//  - RUN: dwell counter increments each clock; at count==dwell (end of phase):
//    * phase<last_phase: phase+1, dwell counter 0, phase_strobe=1.
//    * phase==last_phase, cycles_left>1: phase=0, cycles_left-1,
//      phase_strobe=1, cycle_strobe=1.
//    * phase==last_phase, cycles_left==1: -> DONE, busy=0, phase=0,
//      cycles_left=0.
//  - Strobes are 0 on all other clocks; dwell=0 gives strobes every clock.
//  - DONE: lasts exactly one clock with done=1; start ignored; then IDLE.
//  - abort in RUN: overrides phase advance; next edge -> IDLE, busy=0, phase=0,
//    cycles_left=0, strobes 0, no done pulse. abort ignored in IDLE/DONE.
//  - start while RUN or DONE ignored; config inputs ignored except on start.
//  - last_phase=0: every phase is also a cycle start (both strobes together).
//  - No wrap beyond last_phase; the phase counter never exceeds last_phase.
// CONFIGURATION
//  SINGLE_STEP_EN defined: adds input port step (1 bit). In RUN the end-of-phase
//  event is step=1 instead of dwell expiry; dwell is latched but unused; step
//  outside RUN ignored; abort beats step. Not defined: no step port; timing
//  purely dwell-driven as above.
// TESTING
//  1 num_cycles=2,last_phase=3,dwell=0, start 1 clk -> phase 0,1,2,3,0,1,2,3 on
//    8 clocks, phase_strobe all 8, cycle_strobe clocks 1 and 5, done on clock 9.
//  2 num_cycles=1,last_phase=1,dwell=2 -> phase 0 for 3 clks, 1 for 3 clks,
//    phase_strobe only at clocks 1 and 4, busy 6 clocks, then done 1 clock.
//  3 num_cycles=0 start -> busy never 1, no strobes, done pulse 1 clock later.
//  4 abort at phase 2 of cycle 1 -> next edge busy=0, phase=0, no done; new
//    start accepted the following clock.
//  5 reset_n low mid-RUN -> all outputs 0 without a clock edge; after release
//    start behaves as test 1.
//  6 SINGLE_STEP_EN, last_phase=2,num_cycles=1: phase holds 0 for 10 clks w/o
//    step; 3 step pulses -> phase 1, 2, then done.

Source files
------------

// File: rtl/timing_phase_sequencer.sv
// timing_phase_sequencer: steps a phase index through 0..last_phase for a
// programmed number of cycles. Each phase is held for dwell+1 clocks. The block
// emits phase and cycle strobes and has a start/busy/done handshake.
// Optional feature macro: SINGLE_STEP_EN. When it is defined, a "step" input is
// added and ends each phase in place of the dwell counter expiring.
module timing_phase_sequencer #(
   parameter int PHASE_W = 4,
   parameter int CYC_W   = 8,
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
`ifdef SINGLE_STEP_EN
   input  logic               step,
`endif
   input  logic [CYC_W-1:0]   num_cycles,
   input  logic [PHASE_W-1:0] last_phase,
   input  logic [DWELL_W-1:0] dwell,
   output logic               busy,
   output logic               done,
   output logic [PHASE_W-1:0] phase,
   output logic               phase_strobe,
   output logic               cycle_strobe,
   output logic [CYC_W-1:0]   cycles_left
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               state_reg, state_next;
   logic                 busy_reg, busy_next;
   logic                 done_reg, done_next;
   logic [PHASE_W-1:0]   phase_reg, phase_next;
   logic                 phase_strobe_reg, phase_strobe_next;
   logic                 cycle_strobe_reg, cycle_strobe_next;
   logic [CYC_W-1:0]     cycles_left_reg, cycles_left_next;
   logic [DWELL_W-1:0]   dwell_cnt_reg, dwell_cnt_next;
   logic [DWELL_W-1:0]   dwell_reg, dwell_next;
   logic [PHASE_W-1:0]   last_phase_reg, last_phase_next;
   logic                 end_of_phase;

   // A phase ends either on an external step or when the dwell counter reaches the latched dwell.
`ifdef SINGLE_STEP_EN
   assign end_of_phase = step;
`else
   assign end_of_phase = (dwell_cnt_reg == dwell_reg);
`endif

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= S_IDLE;
         busy_reg         <= 1'b0;
         done_reg         <= 1'b0;
         phase_reg        <= '0;
         phase_strobe_reg <= 1'b0;
         cycle_strobe_reg <= 1'b0;
         cycles_left_reg  <= '0;
         dwell_cnt_reg    <= '0;
         dwell_reg        <= '0;
         last_phase_reg   <= '0;
      end else begin
         state_reg        <= state_next;
         busy_reg         <= busy_next;
         done_reg         <= done_next;
         phase_reg        <= phase_next;
         phase_strobe_reg <= phase_strobe_next;
         cycle_strobe_reg <= cycle_strobe_next;
         cycles_left_reg  <= cycles_left_next;
         dwell_cnt_reg    <= dwell_cnt_next;
         dwell_reg        <= dwell_next;
         last_phase_reg   <= last_phase_next;
      end
   end

   // Next-state and next-output logic. Strobes and done default low so they only pulse.
   always_comb begin
      state_next        = state_reg;
      busy_next         = 1'b0;
      done_next         = 1'b0;
      phase_next        = phase_reg;
      phase_strobe_next = 1'b0;
      cycle_strobe_next = 1'b0;
      cycles_left_next  = cycles_left_reg;
      dwell_cnt_next    = dwell_cnt_reg;
      dwell_next        = dwell_reg;
      last_phase_next   = last_phase_reg;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               dwell_next      = dwell;
               last_phase_next = last_phase;
               dwell_cnt_next  = '0;
               phase_next      = '0;
               if (num_cycles != '0) begin
                  state_next        = S_RUN;
                  busy_next         = 1'b1;
                  phase_strobe_next = 1'b1;
                  cycle_strobe_next = 1'b1;
                  cycles_left_next  = num_cycles;
               end else begin
                  state_next = S_DONE;
                  done_next  = 1'b1;
               end
            end
         end

         S_RUN: begin
            busy_next = 1'b1;
            if (abort) begin
               // Cancel silently: no done pulse.
               state_next       = S_IDLE;
               busy_next        = 1'b0;
               phase_next       = '0;
               cycles_left_next = '0;
               dwell_cnt_next   = '0;
            end else if (end_of_phase) begin
               dwell_cnt_next = '0;
               if (phase_reg < last_phase_reg) begin
                  phase_next        = phase_reg + PHASE_W'(1);
                  phase_strobe_next = 1'b1;
               end else if (cycles_left_reg > CYC_W'(1)) begin
                  phase_next        = '0;
                  cycles_left_next  = cycles_left_reg - CYC_W'(1);
                  phase_strobe_next = 1'b1;
                  cycle_strobe_next = 1'b1;
               end else begin
                  state_next       = S_DONE;
                  busy_next        = 1'b0;
                  done_next        = 1'b1;
                  phase_next       = '0;
                  cycles_left_next = '0;
               end
            end else begin
               dwell_cnt_next = dwell_cnt_reg + DWELL_W'(1);
            end
         end

         S_DONE: begin
            // One clock only; start is not looked at here.
            state_next = S_IDLE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign busy         = busy_reg;
   assign done         = done_reg;
   assign phase        = phase_reg;
   assign phase_strobe = phase_strobe_reg;
   assign cycle_strobe = cycle_strobe_reg;
   assign cycles_left  = cycles_left_reg;

endmodule
